// File: rtl/rs_pkg.sv
// Shared ALU-issue definitions: opcode encodings, datapath widths, issue payload
// and the saturating counter helper used by the optional statistics.
package rs_pkg;

    localparam int OP_W = 6;
    localparam int XLEN = 32;

    localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 6'd1;
    localparam logic [OP_W-1:0] OP_AND  = 6'd2;
    localparam logic [OP_W-1:0] OP_OR   = 6'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 6'd4;
    localparam logic [OP_W-1:0] OP_SLL  = 6'd5;
    localparam logic [OP_W-1:0] OP_SRL  = 6'd6;
    localparam logic [OP_W-1:0] OP_SRA  = 6'd7;
    localparam logic [OP_W-1:0] OP_SLT  = 6'd8;
    localparam logic [OP_W-1:0] OP_SLTU = 6'd9;
    localparam logic [OP_W-1:0] OP_LUI  = 6'd10;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } alu_payload_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set request at or after ptr,
// wrapping modulo N. Purely combinational; N must be a power of two.
module rr_pick #(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          any
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IW-1:0]  offset;

    // Rotate so that bit 0 of req_rot is the request at ptr.
    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[N-1:0];

    always_comb begin
        any    = 1'b0;
        offset = '0;
        for (int k = 0; k < N; k++) begin
            if (!any && req_rot[k]) begin
                any    = 1'b1;
                offset = k[IW-1:0];
            end
        end
    end

    assign index = ptr + offset;
    assign grant = any ? ({{(N-1){1'b0}}, 1'b1} << index) : '0;

endmodule

// File: rtl/rs_issue_sched.sv
// Issue scheduler between reservation station and ALU: rotating-priority pick of one
// ready entry per cycle into a valid/ready output register. Define RS_ISSUE_STATS_EN
// to add the issue/stall statistics counters.
module rs_issue_sched
    import rs_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int RS_SIZE   = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        clear,
    input  logic [RS_SIZE-1:0]          entry_busy,
    input  logic [RS_SIZE-1:0]          entry_ready,
    input  logic [RS_SIZE*OP_W-1:0]     entry_op,
    input  logic [RS_SIZE*XLEN-1:0]     entry_a,
    input  logic [RS_SIZE*XLEN-1:0]     entry_b,
    input  logic [RS_SIZE*ROB_WIDTH-1:0] entry_tag,
    input  logic                        alu_ready,
    output logic [RS_SIZE-1:0]          issue_grant,
    output logic                        to_alu_valid,
    output logic [OP_W-1:0]             to_alu_op,
    output logic [XLEN-1:0]             to_alu_a,
    output logic [XLEN-1:0]             to_alu_b,
    output logic [ROB_WIDTH-1:0]        to_alu_tag
`ifdef RS_ISSUE_STATS_EN
    ,
    output logic [31:0]                 stat_issue_cnt,
    output logic [31:0]                 stat_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [OP_W-1:0]      op_arr  [RS_SIZE];
    logic [XLEN-1:0]      a_arr   [RS_SIZE];
    logic [XLEN-1:0]      b_arr   [RS_SIZE];
    logic [ROB_WIDTH-1:0] tag_arr [RS_SIZE];

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_unpack
        assign op_arr[gi]  = entry_op[gi*OP_W +: OP_W];
        assign a_arr[gi]   = entry_a[gi*XLEN +: XLEN];
        assign b_arr[gi]   = entry_b[gi*XLEN +: XLEN];
        assign tag_arr[gi] = entry_tag[gi*ROB_WIDTH +: ROB_WIDTH];
    end

    logic                 valid_q,   valid_d;
    alu_payload_t         payload_q, payload_d;
    logic [ROB_WIDTH-1:0] tag_q,     tag_d;
    logic [IDX_W-1:0]     rr_ptr_q,  rr_ptr_d;

    logic [RS_SIZE-1:0] eligible;
    logic [RS_SIZE-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               slot_free;
    logic               fire;

    assign eligible = entry_busy & entry_ready;

    rr_pick #(
        .N (RS_SIZE)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .index (pick_idx),
        .any   (pick_any)
    );

    assign slot_free = !valid_q || alu_ready;
    // rst_in is folded in so the grant drops the instant reset asserts.
    assign fire = rst_in && rdy_in && !clear && slot_free && pick_any;

    assign issue_grant = fire ? pick_grant : '0;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        tag_d     = tag_q;
        rr_ptr_d  = rr_ptr_q;
        if (rdy_in) begin
            if (clear) begin
                valid_d  = 1'b0;
                rr_ptr_d = '0;
            end else if (fire) begin
                valid_d   = 1'b1;
                payload_d = '{op: op_arr[pick_idx], a: a_arr[pick_idx], b: b_arr[pick_idx]};
                tag_d     = tag_arr[pick_idx];
                rr_ptr_d  = pick_idx + IDX_W'(1);
            end else if (alu_ready && valid_q) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            tag_q     <= '0;
            rr_ptr_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            tag_q     <= tag_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign to_alu_valid = valid_q;
    assign to_alu_op    = payload_q.op;
    assign to_alu_a     = payload_q.a;
    assign to_alu_b     = payload_q.b;
    assign to_alu_tag   = tag_q;

`ifdef RS_ISSUE_STATS_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counters ignore clear: they measure throughput across flushes.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fire) begin
            issue_cnt_d = sat_inc(issue_cnt_q);
        end
        if (rdy_in && (|eligible) && !slot_free) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_issue_cnt = issue_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rs_issue_sched.sv
// Self-checking bench for rs_issue_sched: reference model plus directed scenarios.
module tb_rs_issue_sched;
    import rs_pkg::*;

    localparam int RW = 4;
    localparam int N  = 8;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             rdy_in;
    logic             clear;
    logic             alu_ready;
    logic [N-1:0]     entry_busy;
    logic [N-1:0]     entry_ready;
    logic [N*OP_W-1:0] entry_op;
    logic [N*XLEN-1:0] entry_a;
    logic [N*XLEN-1:0] entry_b;
    logic [N*RW-1:0]   entry_tag;
    logic [N-1:0]      issue_grant;
    logic              to_alu_valid;
    logic [OP_W-1:0]   to_alu_op;
    logic [XLEN-1:0]   to_alu_a;
    logic [XLEN-1:0]   to_alu_b;
    logic [RW-1:0]     to_alu_tag;
`ifdef RS_ISSUE_STATS_EN
    logic [31:0]       stat_issue_cnt;
    logic [31:0]       stat_stall_cnt;
`endif

    logic [OP_W-1:0] e_op  [N];
    logic [XLEN-1:0] e_a   [N];
    logic [XLEN-1:0] e_b   [N];
    logic [RW-1:0]   e_tag [N];

    always_comb begin
        entry_op  = '0;
        entry_a   = '0;
        entry_b   = '0;
        entry_tag = '0;
        for (int i = 0; i < N; i++) begin
            entry_op[i*OP_W +: OP_W] = e_op[i];
            entry_a[i*XLEN +: XLEN]  = e_a[i];
            entry_b[i*XLEN +: XLEN]  = e_b[i];
            entry_tag[i*RW +: RW]    = e_tag[i];
        end
    end

    always #5 clk_in = ~clk_in;

    rs_issue_sched #(.ROB_WIDTH(RW), .RS_SIZE(N)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear        (clear),
        .entry_busy   (entry_busy),
        .entry_ready  (entry_ready),
        .entry_op     (entry_op),
        .entry_a      (entry_a),
        .entry_b      (entry_b),
        .entry_tag    (entry_tag),
        .alu_ready    (alu_ready),
        .issue_grant  (issue_grant),
        .to_alu_valid (to_alu_valid),
        .to_alu_op    (to_alu_op),
        .to_alu_a     (to_alu_a),
        .to_alu_b     (to_alu_b),
        .to_alu_tag   (to_alu_tag)
`ifdef RS_ISSUE_STATS_EN
        ,
        .stat_issue_cnt (stat_issue_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scheduler state described by its observable rules.
    logic            m_valid;
    logic [OP_W-1:0] m_op;
    logic [XLEN-1:0] m_a;
    logic [XLEN-1:0] m_b;
    logic [RW-1:0]   m_tag;
    int              m_ptr;
    int              m_issue;
    int              m_stall;

    function automatic int first_elig();
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (entry_busy[idx] && entry_ready[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        int s;
        if (!rst_in || !rdy_in || clear) return '0;
        if (m_valid && !alu_ready) return '0;
        s = first_elig();
        if (s < 0) return '0;
        return N'(1) << s;
    endfunction

    always @(posedge clk_in or negedge rst_in) begin
        int  sel;
        logic free;
        if (!rst_in) begin
            m_valid <= 1'b0;
            m_op    <= '0;
            m_a     <= '0;
            m_b     <= '0;
            m_tag   <= '0;
            m_ptr   <= 0;
            m_issue <= 0;
            m_stall <= 0;
        end else if (rdy_in) begin
            sel  = first_elig();
            free = !m_valid || alu_ready;
            if (sel >= 0 && !free) m_stall <= m_stall + 1;
            if (clear) begin
                m_valid <= 1'b0;
                m_ptr   <= 0;
            end else if (free && sel >= 0) begin
                m_valid <= 1'b1;
                m_op    <= e_op[sel];
                m_a     <= e_a[sel];
                m_b     <= e_b[sel];
                m_tag   <= e_tag[sel];
                m_ptr   <= (sel + 1) % N;
                m_issue <= m_issue + 1;
            end else if (alu_ready && m_valid) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        check("grant", 32'(issue_grant), 32'(exp_grant()));
        check("valid", 32'(to_alu_valid), 32'(m_valid));
        if (m_valid) begin
            check("op",  32'(to_alu_op),  32'(m_op));
            check("a",   to_alu_a,        m_a);
            check("b",   to_alu_b,        m_b);
            check("tag", 32'(to_alu_tag), 32'(m_tag));
        end
`ifdef RS_ISSUE_STATS_EN
        check("stat_issue", stat_issue_cnt, 32'(m_issue));
        check("stat_stall", stat_stall_cnt, 32'(m_stall));
`endif
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_ent(input int i, input logic rdy, input logic [OP_W-1:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [RW-1:0] tag);
        entry_busy[i]  = 1'b1;
        entry_ready[i] = rdy;
        e_op[i]  = op;
        e_a[i]   = a;
        e_b[i]   = b;
        e_tag[i] = tag;
    endtask

    initial begin
        logic [N-1:0] rr_exp [4];
        rr_exp[0] = 8'b0000_0001;
        rr_exp[1] = 8'b0000_0100;
        rr_exp[2] = 8'b1000_0000;
        rr_exp[3] = 8'b0000_0001;

        rst_in      = 1'b0;
        rdy_in      = 1'b1;
        clear       = 1'b0;
        alu_ready   = 1'b0;
        entry_busy  = '0;
        entry_ready = '0;
        for (int i = 0; i < N; i++) begin
            e_op[i] = '0; e_a[i] = '0; e_b[i] = '0; e_tag[i] = '0;
        end

        repeat (2) tick();
        #1;
        check("rst_valid", 32'(to_alu_valid), 32'd0);
        check("rst_grant", 32'(issue_grant), 32'd0);
        check("rst_op", 32'(to_alu_op), 32'd0);
        check("rst_a", to_alu_a, 32'd0);
        rst_in = 1'b1;
        tick();

        // Single issue of entry 3
        set_ent(3, 1'b1, OP_ADD, 32'd5, 32'd7, 4'd2);
        #1 check("single_grant", 32'(issue_grant), 32'h08);
        tick();
        entry_busy[3] = 1'b0;
        #1;
        check("single_valid", 32'(to_alu_valid), 32'd1);
        check("single_op", 32'(to_alu_op), 32'(OP_ADD));
        check("single_a", to_alu_a, 32'd5);
        check("single_b", to_alu_b, 32'd7);
        check("single_tag", 32'(to_alu_tag), 32'd2);

        // Flush with nothing eligible returns the pointer to 0
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1 check("clr_valid", 32'(to_alu_valid), 32'd0);

        // Round-robin over entries 0, 2, 7
        set_ent(0, 1'b1, OP_SUB, 32'd10, 32'd1, 4'd1);
        set_ent(2, 1'b1, OP_XOR, 32'd20, 32'd2, 4'd3);
        set_ent(7, 1'b1, OP_LUI, 32'd70, 32'd7, 4'd6);
        alu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("rr_grant", 32'(issue_grant), 32'(rr_exp[i]));
            tick();
        end
        entry_busy = '0;
        #1 check("rr_last_a", to_alu_a, 32'd10);

        // Stall: held payload, no grant for 3 cycles
        alu_ready = 1'b0;
        set_ent(1, 1'b1, OP_AND, 32'd11, 32'd12, 4'd5);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_grant", 32'(issue_grant), 32'd0);
            check("stall_a", to_alu_a, 32'd10);
            tick();
        end
        alu_ready = 1'b1;
        #1 check("stall_release", 32'(issue_grant), 32'h02);
        tick();
        entry_busy[1] = 1'b0;
        #1 check("stall_op", 32'(to_alu_op), 32'(OP_AND));

        // Flush while valid with entry 4 eligible
        set_ent(4, 1'b1, OP_OR, 32'd40, 32'd41, 4'd9);
        clear = 1'b1;
        #1 check("flush_grant", 32'(issue_grant), 32'd0);
        tick();
        clear = 1'b0;
        set_ent(1, 1'b1, OP_SLL, 32'd13, 32'd14, 4'd1);
        #1;
        check("flush_valid", 32'(to_alu_valid), 32'd0);
        check("flush_ptr0", 32'(issue_grant), 32'h02);
        tick();
        entry_busy[1] = 1'b0;
        #1 check("flush_op", 32'(to_alu_op), 32'(OP_SLL));

        // Freeze: rdy_in low, clear ignored, state held
        set_ent(1, 1'b1, OP_SLT, 32'd15, 32'd16, 4'd4);
        rdy_in = 1'b0;
        clear  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 check("frz_grant", 32'(issue_grant), 32'd0);
            tick();
        end
        #1;
        check("frz_valid", 32'(to_alu_valid), 32'd1);
        check("frz_op", 32'(to_alu_op), 32'(OP_SLL));
        rdy_in = 1'b1;
        clear  = 1'b0;
        #1 check("frz_ptr_kept", 32'(issue_grant), 32'h10);
        tick();
        #1 check("frz_issue_a", to_alu_a, 32'd40);

        // Async reset mid-cycle with a valid payload
        set_ent(6, 1'b1, OP_SRA, 32'd60, 32'd61, 4'd7);
        #1 rst_in = 1'b0;
        #1;
        check("arst_valid", 32'(to_alu_valid), 32'd0);
        check("arst_grant", 32'(issue_grant), 32'd0);
        check("arst_op", 32'(to_alu_op), 32'd0);
        rst_in = 1'b1;
        #1 check("arst_ptr0", 32'(issue_grant), 32'h02);

        // 10 issues then 3 stalled cycles
        repeat (10) tick();
        alu_ready = 1'b0;
        repeat (3) tick();
        #1;
`ifdef RS_ISSUE_STATS_EN
        check("stat_issue_10", stat_issue_cnt, 32'd10);
        check("stat_stall_3", stat_stall_cnt, 32'd3);
`endif
        check("end_grant", 32'(issue_grant), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
